// File: rtl/ctrlpid_mc.sv
// Multi-channel incremental PID controller: one shared datapath sweeps every
// channel once per prescaler tick, keeping per-channel accumulator and error history.
module ctrlpid_mc #(
  parameter int aw         = 1,
  parameter int ow         = 12,
  parameter int ew         = 24,
  parameter int pw         = 32,
  parameter int cw         = 6,
  parameter int fp         = 9,
  parameter int precision  = 1,
  parameter int psw        = 5,
  parameter int antiwindup = int'(8'hFF) << (precision + ow - 9)
) (
  input  logic          clk_pid,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [ew-1:0] error,
  input  logic [cw-1:0] KP,
  input  logic [cw-1:0] KI,
  input  logic [cw-1:0] KD,
  input  logic          clr,
  output logic [aw-1:0] a,
  output logic [ow-1:0] m_k_out,
  output logic [aw-1:0] ch,
  output logic          ce,
  output logic          sat,
  output logic          busy
);

  localparam int an = 1 << aw;
  localparam int sw = cw + 2;
  localparam logic signed [pw-1:0] lim_p = pw'(antiwindup);
  localparam logic signed [pw-1:0] lim_n = -lim_p;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_P, S_D, S_I, S_CLAMP, S_OUT, S_SHIFT
  } state_e;

  state_e                 state_q, state_d;
  logic [psw-1:0]         pre_q, pre_d;
  logic                   armed_q, armed_d;
  logic [aw-1:0]          a_q, a_d;
  logic signed [pw-1:0]   e0_q, e0_d;
  logic signed [sw-1:0]   sp_q, sp_d, sd_q, sd_d, si_q, si_d;
  logic                   clr_i_q, clr_i_d;
  logic                   sat_i_q, sat_i_d;
  logic [ow-1:0]          m_q, m_d;
  logic [aw-1:0]          ch_q, ch_d;
  logic                   ce_q, ce_d;
  logic                   sat_q, sat_d;
  logic                   busy_q, busy_d;
  logic signed [pw-1:0]   u_q [an];
  logic signed [pw-1:0]   u_d [an];
  logic signed [pw-1:0]   e1_q [an];
  logic signed [pw-1:0]   e1_d [an];
  logic signed [pw-1:0]   e2_q [an];
  logic signed [pw-1:0]   e2_d [an];

  logic                   tick;
  logic signed [sw-1:0]   sd1;

  // Signed power-of-two gain: left shift for s >= 0, arithmetic right shift otherwise.
  function automatic logic signed [pw-1:0] sh(input logic signed [pw-1:0] x,
                                              input logic signed [sw-1:0] s);
    logic [sw-1:0] n;
    n = (s < 0) ? -s : s;
    return (s < 0) ? (x >>> n) : (x <<< n);
  endfunction

  // The zero the prescaler holds out of reset is not a tick; the first one
  // comes only after a full prescaler period.
  assign tick = (pre_q == '0) && armed_q;
  assign sd1  = sw'(sd_q + 1);

  always_comb begin
    // NOTE: every _d takes its _q value first, so no path through the case can infer a latch.
    state_d = state_q;
    pre_d   = pre_q + psw'(1);
    armed_d = armed_q | (pre_q == '1);
    a_d     = a_q;
    e0_d    = e0_q;
    sp_d    = sp_q;
    sd_d    = sd_q;
    si_d    = si_q;
    clr_i_d = clr_i_q;
    sat_i_d = sat_i_q;
    m_d     = m_q;
    ch_d    = ch_q;
    ce_d    = 1'b0;
    sat_d   = sat_q;
    u_d     = u_q;
    e1_d    = e1_q;
    e2_d    = e2_q;

    case (state_q)
      S_IDLE: begin
        if (tick && enable) begin
          state_d = S_LOAD;
          a_d     = '0;
        end
      end
      S_LOAD: begin
        e0_d    = pw'($signed(error));
        sp_d    = sw'($signed(KP)) + sw'(precision);
        sd_d    = sw'($signed(KD)) + sw'(precision + fp);
        si_d    = sw'($signed(KI)) + sw'(precision - 1 - fp);
        clr_i_d = clr;
        if (clr) begin
          u_d[a_q]  = '0;
          e1_d[a_q] = '0;
          e2_d[a_q] = '0;
        end
        state_d = S_P;
      end
      S_P: begin
        if (!clr_i_q)
          u_d[a_q] = u_q[a_q] + sh(e0_q, sp_q) - sh(e1_q[a_q], sp_q);
        state_d = S_D;
      end
      S_D: begin
        if (!clr_i_q)
          u_d[a_q] = u_q[a_q] + sh(e0_q, sd_q) + sh(e2_q[a_q], sd_q)
                   - sh(e1_q[a_q], sd1);
        state_d = S_I;
      end
      S_I: begin
        if (!clr_i_q)
          u_d[a_q] = u_q[a_q] + sh(e0_q, si_q) + sh(e1_q[a_q], si_q);
        state_d = S_CLAMP;
      end
      S_CLAMP: begin
        if (u_q[a_q] > lim_p) begin
          u_d[a_q] = lim_p;
          sat_i_d  = 1'b1;
        end else if (u_q[a_q] < lim_n) begin
          u_d[a_q] = lim_n;
          sat_i_d  = 1'b1;
        end else begin
          sat_i_d  = 1'b0;
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        m_d     = u_q[a_q][precision+ow-1:precision];
        ch_d    = a_q;
        sat_d   = sat_i_q;
        ce_d    = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        e2_d[a_q] = e1_q[a_q];
        e1_d[a_q] = e0_q;
        if (a_q != aw'(an - 1)) begin
          a_d     = a_q + aw'(1);
          state_d = S_LOAD;
        end else begin
          a_d     = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_pid or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      armed_q <= 1'b0;
      a_q     <= '0;
      e0_q    <= '0;
      sp_q    <= '0;
      sd_q    <= '0;
      si_q    <= '0;
      clr_i_q <= 1'b0;
      sat_i_q <= 1'b0;
      m_q     <= '0;
      ch_q    <= '0;
      ce_q    <= 1'b0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      // NOTE: the per-channel history is small flop storage, not RAM, and a reset must restart every loop from zero.
      for (int i = 0; i < an; i++) begin
        u_q[i]  <= '0;
        e1_q[i] <= '0;
        e2_q[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments only, so every flop samples the pre-edge values.
      state_q <= state_d;
      pre_q   <= pre_d;
      armed_q <= armed_d;
      a_q     <= a_d;
      e0_q    <= e0_d;
      sp_q    <= sp_d;
      sd_q    <= sd_d;
      si_q    <= si_d;
      clr_i_q <= clr_i_d;
      sat_i_q <= sat_i_d;
      m_q     <= m_d;
      ch_q    <= ch_d;
      ce_q    <= ce_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
      u_q     <= u_d;
      e1_q    <= e1_d;
      e2_q    <= e2_d;
    end
  end

  assign a       = a_q;
  assign m_k_out = m_q;
  assign ch      = ch_q;
  assign ce      = ce_q;
  assign sat     = sat_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ctrlpid_mc.sv
// Bench for ctrlpid_mc: directed vectors plus randomized sweeps, every ce checked
// against a per-channel arithmetic model of the PID update.
module tb_ctrlpid_mc;

  localparam int aw  = 1;
  localparam int an  = 2;
  localparam int ow  = 12;
  localparam int ew  = 24;
  localparam int cw  = 6;
  localparam longint LIM = 4080;

  logic          clk_pid = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [ew-1:0] error;
  logic [cw-1:0] KP, KI, KD;
  logic          clr;
  logic [aw-1:0] a, ch;
  logic [ow-1:0] m_k_out;
  logic          ce, sat, busy;

  logic signed [ew-1:0] err_tab [an];
  logic signed [cw-1:0] kp_tab  [an];
  logic signed [cw-1:0] ki_tab  [an];
  logic signed [cw-1:0] kd_tab  [an];
  logic                 clr_tab [an];

  assign error = err_tab[a];
  assign KP    = kp_tab[a];
  assign KI    = ki_tab[a];
  assign KD    = kd_tab[a];
  assign clr   = clr_tab[a];

  ctrlpid_mc dut (
    .clk_pid(clk_pid), .reset_n(reset_n), .enable(enable), .error(error),
    .KP(KP), .KI(KI), .KD(KD), .clr(clr), .a(a), .m_k_out(m_k_out),
    .ch(ch), .ce(ce), .sat(sat), .busy(busy)
  );

  always #5 clk_pid = ~clk_pid;

  typedef struct {
    logic [aw-1:0] ch;
    logic [ow-1:0] out;
    logic          sat;
  } exp_t;

  exp_t   exp_q [$];
  longint mu [an];
  longint me1 [an];
  longint me2 [an];
  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  int     load_cyc = 0;
  int     ce_cnt   = 0;
  logic   busy_prev = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  function automatic longint wrap32(input longint v);
    int t;
    t = int'(v);
    return longint'(t);
  endfunction

  // x * 2^s, or floor(x / 2^-s) for negative s.
  function automatic longint shm(input longint x, input int s);
    if (s >= 0) return x * (longint'(1) << s);
    return x >>> (-s);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < an; c++) begin
      mu[c] = 0; me1[c] = 0; me2[c] = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_sweep();
    for (int c = 0; c < an; c++) begin
      longint e0;
      int sp, sd, si;
      exp_t x;
      e0 = longint'(err_tab[c]);
      sp = int'(kp_tab[c]) + 1;
      sd = int'(kd_tab[c]) + 1 + 9;
      si = int'(ki_tab[c]) - 9;
      x.sat = 1'b0;
      if (clr_tab[c]) begin
        mu[c] = 0; me1[c] = 0; me2[c] = 0;
      end else begin
        mu[c] = wrap32(mu[c] + shm(e0, sp) - shm(me1[c], sp));
        mu[c] = wrap32(mu[c] + shm(e0, sd) + shm(me2[c], sd) - shm(me1[c], sd + 1));
        mu[c] = wrap32(mu[c] + shm(e0, si) + shm(me1[c], si));
        if (mu[c] > LIM) begin
          mu[c] = LIM; x.sat = 1'b1;
        end else if (mu[c] < -LIM) begin
          mu[c] = -LIM; x.sat = 1'b1;
        end
      end
      x.out = ow'(mu[c] >>> 1);
      x.ch  = aw'(c);
      me2[c] = me1[c];
      me1[c] = e0;
      exp_q.push_back(x);
    end
  endtask

  always @(posedge clk_pid) cyc++;

  always @(negedge clk_pid) begin
    if (busy && !busy_prev) load_cyc = cyc;
    busy_prev = busy;
    if (ce) begin
      if (exp_q.size() == 0) begin
        check("spurious_ce", ce, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("ch", ch, e.ch);
        check("m_k_out", m_k_out, e.out);
        check("sat", sat, e.sat);
        check("ce_latency", cyc - load_cyc, 6 + 7 * int'(e.ch));
        ce_cnt++;
      end
    end
  end

  task automatic set_all(input int err, input int kp, input int ki, input int kd);
    for (int c = 0; c < an; c++) begin
      err_tab[c] = ew'(err); kp_tab[c] = cw'(kp);
      ki_tab[c]  = cw'(ki);  kd_tab[c] = cw'(kd);
      clr_tab[c] = 1'b0;
    end
  endtask

  task automatic hold_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_pid);
  endtask

  task automatic wait_sweep();
    int n;
    n = 0;
    while (!busy && n < 80) begin @(negedge clk_pid); n++; end
    check("sweep_start", busy, 1);
    n = 0;
    while (busy && n < 40) begin @(negedge clk_pid); n++; end
    check("sweep_end", busy, 0);
  endtask

  task automatic next_sweep();
    model_sweep();
    wait_sweep();
    check("exp_drained", exp_q.size(), 0);
  endtask

  // Releases reset with enable high and checks the first tick lands a full prescaler period later.
  task automatic start_after_reset();
    enable = 1'b1;
    model_sweep();
    reset_n = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk_pid);
      if (k == 32) check("first_tick_early", busy, 0);
      if (k == 33) check("first_tick_load", busy, 1);
    end
    wait_sweep();
    check("exp_drained", exp_q.size(), 0);
  endtask

  initial begin
    int ce0;
    int n;
    logic seen_busy;
    reset_n = 1'b0;
    enable  = 1'b0;
    set_all(0, 0, 0, 0);
    hold_reset();
    check("rst_m_k_out", m_k_out, 0);
    check("rst_ch", ch, 0);
    check("rst_ce", ce, 0);
    check("rst_sat", sat, 0);
    check("rst_busy", busy, 0);
    check("rst_a", a, 0);

    // Proportional only.
    set_all(100, 0, -20, -20);
    start_after_reset();
    next_sweep();
    check("p_only_out", m_k_out, 100);
    check("p_only_sat", sat, 0);

    // Integral only.
    hold_reset();
    set_all(100, -20, 9, -20);
    start_after_reset();
    next_sweep();
    next_sweep();
    check("integral_out", m_k_out, 250);

    // Antiwindup clamp in both directions.
    hold_reset();
    set_all(100, 10, -20, -20);
    start_after_reset();
    check("aw_pos_out", m_k_out, 2040);
    check("aw_pos_sat", sat, 1);
    set_all(-100, 10, -20, -20);
    next_sweep();
    check("aw_neg_out", m_k_out, 12'h808);
    check("aw_neg_sat", sat, 1);

    // Clear channel 1 only; channel 0 keeps evolving as if untouched.
    set_all(300, 2, 5, -3);
    clr_tab[1] = 1'b1;
    next_sweep();
    check("clr_out", m_k_out, 0);
    check("clr_sat", sat, 0);
    clr_tab[1] = 1'b0;
    next_sweep();

    // Enable dropped mid-sweep: the sweep still completes, then nothing more runs.
    enable = 1'b1;
    model_sweep();
    ce0 = ce_cnt;
    n = 0;
    while (!busy && n < 80) begin @(negedge clk_pid); n++; end
    check("en_drop_start", busy, 1);
    repeat (3) @(negedge clk_pid);
    enable = 1'b0;
    n = 0;
    while (busy && n < 40) begin @(negedge clk_pid); n++; end
    check("en_drop_ces", ce_cnt - ce0, an);
    ce0 = ce_cnt;
    seen_busy = 1'b0;
    repeat (80) begin @(negedge clk_pid); seen_busy |= busy; end
    check("disabled_busy", seen_busy, 0);
    check("disabled_ces", ce_cnt - ce0, 0);

    // Randomized sweeps, alternating small-signal and full-range operands.
    enable = 1'b1;
    for (int s = 0; s < 24; s++) begin
      for (int c = 0; c < an; c++) begin
        if (s % 2 == 0) begin
          err_tab[c] = ew'(int'($urandom_range(0, 4000)) - 2000);
          kp_tab[c]  = cw'(int'($urandom_range(0, 11)) - 8);
          ki_tab[c]  = cw'(int'($urandom_range(0, 10)));
          kd_tab[c]  = cw'(int'($urandom_range(0, 12)) - 14);
        end else begin
          err_tab[c] = ew'($urandom);
          kp_tab[c]  = cw'($urandom);
          ki_tab[c]  = cw'($urandom);
          kd_tab[c]  = cw'($urandom);
        end
        clr_tab[c] = ($urandom_range(0, 7) == 0);
      end
      next_sweep();
    end

    // Reset asserted at T+9 of a sweep: outputs clear and stay quiet.
    for (int c = 0; c < an; c++) clr_tab[c] = 1'b0;
    model_sweep();
    n = 0;
    while (!busy && n < 80) begin @(negedge clk_pid); n++; end
    check("rst_mid_start", busy, 1);
    repeat (8) @(negedge clk_pid);
    reset_n = 1'b0;
    model_reset();
    @(negedge clk_pid);
    check("rst_mid_m_k_out", m_k_out, 0);
    check("rst_mid_ch", ch, 0);
    check("rst_mid_ce", ce, 0);
    check("rst_mid_sat", sat, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_a", a, 0);
    enable = 1'b0;
    @(negedge clk_pid);
    reset_n = 1'b1;
    ce0 = ce_cnt;
    seen_busy = 1'b0;
    repeat (80) begin @(negedge clk_pid); seen_busy |= busy; end
    check("post_rst_busy", seen_busy, 0);
    check("post_rst_ces", ce_cnt - ce0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
